// File: rtl/fp_regfile_wb_arbiter.sv
// Write-port controller for the FP register file: clears every register after reset,
// then round-robins the single write port between ALU and load writebacks.
module fp_regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  rf_write_En,
    output logic [ADDR_WIDTH-1:0] rf_writeAddr,
    output logic [DATA_WIDTH-1:0] rf_data_in,
    output logic                  init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   count_q;
    logic                    last_ld_q;
    logic                    init_done_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    accept_en;

    // last_ld_q=1 means the load side won the previous transfer, so the ALU wins a tie.
    assign accept_en = init_done_q & ~Rst;
    assign alu_ready = accept_en & alu_valid & (~ld_valid | last_ld_q);
    assign ld_ready  = accept_en & ld_valid & (~alu_valid | ~last_ld_q);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_INIT;
            count_q     <= '0;
            last_ld_q   <= 1'b1;
            init_done_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    we_q    <= 1'b1;
                    addr_q  <= count_q;
                    data_q  <= '0;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!init_done_q) begin
                        // One drain cycle after the last clear write before opening the port.
                        init_done_q <= 1'b1;
                        we_q        <= 1'b0;
                    end else if (alu_ready) begin
                        we_q      <= 1'b1;
                        addr_q    <= alu_addr;
                        data_q    <= alu_data;
                        last_ld_q <= 1'b0;
                    end else if (ld_ready) begin
                        we_q      <= 1'b1;
                        addr_q    <= ld_addr;
                        data_q    <= ld_data;
                        last_ld_q <= 1'b1;
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign rf_write_En  = we_q;
    assign rf_writeAddr = addr_q;
    assign rf_data_in   = data_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_fp_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus predicts grants and queues expected writes stamped with
// the cycle they must appear; a monitor compares the write port every cycle.
module tb_fp_regfile_wb_arbiter;

    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]  alu_addr = '0, ld_addr = '0;
    logic [63:0] alu_data = '0, ld_data = '0;
    logic        alu_ready, ld_ready, rf_write_En, init_done;
    logic [4:0]  rf_writeAddr;
    logic [63:0] rf_data_in;

    fp_regfile_wb_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .Clk(clk), .Rst(Rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_write_En(rf_write_En), .rf_writeAddr(rf_writeAddr), .rf_data_in(rf_data_in),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  done_cyc = BIG;
    bit  in_reset = 1'b1;
    bit  last_ld = 1'b1;
    bit  mon_en = 1'b0;

    // Pending requester state (held until the model says it was accepted)
    logic        rst_drv = 1'b1;
    logic        a_v = 1'b0, l_v = 1'b0;
    logic [4:0]  a_a = '0, l_a = '0;
    logic [63:0] a_d = '0, l_d = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [4:0] a, input logic [63:0] d);
        wr_t e;
        e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // One request cycle: drive, update the reference model, check readiness, queue writes.
    task automatic step();
        bit en, ga, gl;
        @(negedge clk); #2;
        Rst = rst_drv;
        alu_valid = a_v; alu_addr = a_a; alu_data = a_d;
        ld_valid = l_v;  ld_addr = l_a;  ld_data = l_d;
        if (rst_drv) begin
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
            done_cyc = BIG;
            in_reset = 1'b1;
            last_ld = 1'b1;
        end else if (in_reset) begin
            in_reset = 1'b0;
            for (int i = 0; i < 32; i++) push(cyc + 1 + i, 5'(i), 64'd0);
            done_cyc = cyc + 33;
        end
        #1;
        en = !rst_drv && (cyc >= done_cyc);
        ga = en && a_v && (!l_v || last_ld);
        gl = en && l_v && (!a_v || !last_ld);
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, ga});
        chk("ld_ready", {63'd0, ld_ready}, {63'd0, gl});
        if (ga) begin
            push(cyc + 1, a_a, a_d);
            a_v = 1'b0;
            last_ld = 1'b0;
        end else if (gl) begin
            push(cyc + 1, l_a, l_d);
            l_v = 1'b0;
            last_ld = 1'b1;
        end
    endtask

    task automatic reset_seq(input int n);
        rst_drv = 1'b1;
        repeat (n) step();
        @(negedge clk); #1;
        chk("rst_we", {63'd0, rf_write_En}, 64'd0);
        chk("rst_addr", {59'd0, rf_writeAddr}, 64'd0);
        chk("rst_data", rf_data_in, 64'd0);
        chk("rst_init_done", {63'd0, init_done}, 64'd0);
        rst_drv = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((a_v || l_v) && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (a_v || l_v) begin
            errors++;
            $display("FAIL accept_timeout: got pending alu=%0b ld=%0b expected none", a_v, l_v);
            a_v = 1'b0;
            l_v = 1'b0;
        end
    endtask

    // Monitor: every cycle the write port must match the front of the scoreboard or be idle.
    initial begin
        wr_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write: got none expected addr %0d data %h at cycle %0d", e.addr, e.data, e.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("wr_en", {63'd0, rf_write_En}, 64'd1);
                chk("wr_addr", {59'd0, rf_writeAddr}, {59'd0, e.addr});
                chk("wr_data", rf_data_in, e.data);
            end else begin
                chk("idle_we", {63'd0, rf_write_En}, 64'd0);
            end
            chk("init_done", {63'd0, init_done}, {63'd0, (cyc >= done_cyc)});
        end
    end

    initial begin
        // 1. reset, then the clear sequence with no requests
        reset_seq(2);
        mon_en = 1'b1;
        repeat (36) step();

        // 2. single ALU write
        a_v = 1'b1; a_a = 5'd5; a_d = 64'h4009_21FB_5444_2D18;
        step();
        chk("single_alu_accept", {63'd0, a_v}, 64'd0);
        repeat (2) step();

        // 4. load stream of 8 back-to-back writes
        for (int i = 0; i < 8; i++) begin
            l_v = 1'b1; l_a = 5'(i); l_d = 64'hD000_0000_0000_0000 | 64'(i);
            step();
            chk("stream_accept", {63'd0, l_v}, 64'd0);
        end

        // 3. contention: ALU 1,2 vs LD 10,11 -> alternating writes
        a_v = 1'b1; a_a = 5'd1; a_d = 64'hA1;
        l_v = 1'b1; l_a = 5'd10; l_d = 64'hB10;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!a_v && a_a == 5'd1) begin a_v = 1'b1; a_a = 5'd2; a_d = 64'hA2; end
            else if (!a_v && a_a == 5'd2) a_a = 5'd0;
            if (!l_v && l_a == 5'd10) begin l_v = 1'b1; l_a = 5'd11; l_d = 64'hB11; end
            else if (!l_v && l_a == 5'd11) l_a = 5'd0;
        end
        wait_idle(8);
        repeat (2) step();

        // 5. ALU request raised during the clear sequence
        reset_seq(2);
        a_v = 1'b1; a_a = 5'd3; a_d = 64'h3333_0000_1111_2222;
        wait_idle(60);
        repeat (3) step();

        // randomized traffic, including same-address collisions
        for (int i = 0; i < 300; i++) begin
            if (!a_v && ($urandom % 3 == 0)) begin
                a_v = 1'b1; a_a = 5'($urandom); a_d = {$urandom, $urandom};
            end
            if (!l_v && ($urandom % 3 == 0)) begin
                l_v = 1'b1; l_a = 5'($urandom); l_d = {$urandom, $urandom};
            end
            step();
        end
        wait_idle(8);

        // 6. reset in the same cycle a load to 9 is offered
        l_v = 1'b1; l_a = 5'd9; l_d = 64'h9999;
        reset_seq(1);
        l_v = 1'b0;
        repeat (40) step();

        repeat (4) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
